wb_port_arbiter: RTL and testbench

Arbitrates the single register-file write port between the in-order pipeline writeback (EX/WB stage outputs) and a long-latency unit (LU, e.g. multiplier/divider or slow-load return). The pipeline normally wins; a starvation counter guarantees LU progress by granting the port to the LU and parking the displaced pipeline write in a one-entry hold buffer while the front of the pipeline is stalled for one cycle. Sits between the EX/WB pipeline register, the LU result interface and the register file.

---
 rtl/wb_port_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_wb_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the single register-file write port between the in-order pipeline
// writeback and a long-latency unit (LU). The pipeline normally wins. A
// saturating starvation counter forces the LU through after STARVE_LIMIT lost
// cycles; the displaced pipeline write is parked in a one-entry hold buffer,
// the front of the pipe is stalled for one cycle, and the held write commits
// in the following (HOLD) cycle.
//
// Ports
//   clk, rst_n              core clock, asynchronous active-low reset
//   i_pipe_reg_write        EX/WB writeback enable
//   i_pipe_rd               EX/WB destination register
//   i_pipe_alu_result       EX/WB ALU result
//   i_pipe_mem_data         EX/WB load data
//   i_pipe_mem_to_reg       selects load data over ALU result
//   i_lu_valid/rd/data      LU result request (held stable until accepted)
//   o_lu_ready              LU result accepted this cycle
//   o_rf_we/waddr/wdata     register-file write port (combinational)
//   o_stall_req             freeze IF/EX and bubble EX/WB this cycle
//   o_hold_valid/rd/data    hold-buffer contents, for forwarding
//   o_proto_err             sticky: pipeline write arrived while in HOLD
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_pipe_reg_write,
   input  logic [4:0]  i_pipe_rd,
   input  logic [31:0] i_pipe_alu_result,
   input  logic [31:0] i_pipe_mem_data,
   input  logic        i_pipe_mem_to_reg,
   input  logic        i_lu_valid,
   input  logic [4:0]  i_lu_rd,
   input  logic [31:0] i_lu_data,
   output logic        o_lu_ready,
   output logic        o_rf_we,
   output logic [4:0]  o_rf_waddr,
   output logic [31:0] o_rf_wdata,
   output logic        o_stall_req,
   output logic        o_hold_valid,
   output logic [4:0]  o_hold_rd,
   output logic [31:0] o_hold_data,
   output logic        o_proto_err
);

   // A zero limit still needs a one-bit counter to keep the logic well formed.
   localparam int            CW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [CW-1:0] r_wait_cnt;
   logic [CW-1:0] w_wait_cnt_next;
   logic [CW-1:0] w_wait_inc;
   logic          r_hold_valid;
   logic [4:0]    r_hold_rd;
   logic [31:0]   r_hold_data;
   logic          r_proto_err;

   logic          w_pipe_req;
   logic [31:0]   w_pipe_data;
   logic          w_lu_req;
   logic          w_lu_zero;
   logic          w_forced;
   logic          w_capture;
   logic          w_we;
   logic [4:0]    w_waddr;
   logic [31:0]   w_wdata;
   logic          w_lu_ready;
   logic          w_stall;

   assign w_pipe_req  = i_pipe_reg_write && (i_pipe_rd != 5'd0);
   assign w_pipe_data = i_pipe_mem_to_reg ? i_pipe_mem_data : i_pipe_alu_result;
   assign w_lu_req    = i_lu_valid && (i_lu_rd != 5'd0);
   // Writes to x0 are architecturally discarded, so the LU is simply acked.
   assign w_lu_zero   = i_lu_valid && (i_lu_rd == 5'd0);
   assign w_forced    = (r_wait_cnt >= LIMIT);
   assign w_wait_inc  = w_forced ? r_wait_cnt : (r_wait_cnt + CW'(1));

   always_comb begin
      w_state_next    = r_state;
      w_wait_cnt_next = r_wait_cnt;
      w_we            = 1'b0;
      w_waddr         = 5'd0;
      w_wdata         = 32'd0;
      w_lu_ready      = w_lu_zero;
      w_stall         = 1'b0;
      w_capture       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_pipe_req && w_lu_req) begin
               if (w_forced) begin
                  // LU takes the port; pipe write is parked for next cycle.
                  w_we            = 1'b1;
                  w_waddr         = i_lu_rd;
                  w_wdata         = i_lu_data;
                  w_lu_ready      = 1'b1;
                  w_wait_cnt_next = '0;
                  w_capture       = 1'b1;
                  w_stall         = 1'b1;
                  w_state_next    = S_HOLD;
               end else begin
                  w_we            = 1'b1;
                  w_waddr         = i_pipe_rd;
                  w_wdata         = w_pipe_data;
                  w_wait_cnt_next = w_wait_inc;
               end
            end else if (w_pipe_req) begin
               w_we    = 1'b1;
               w_waddr = i_pipe_rd;
               w_wdata = w_pipe_data;
               if (!i_lu_valid) begin
                  w_wait_cnt_next = '0;
               end
            end else if (w_lu_req) begin
               w_we            = 1'b1;
               w_waddr         = i_lu_rd;
               w_wdata         = i_lu_data;
               w_lu_ready      = 1'b1;
               w_wait_cnt_next = '0;
            end else if (!i_lu_valid) begin
               w_wait_cnt_next = '0;
            end
         end
         S_HOLD: begin
            // The held write always wins; a pending LU keeps accruing wait.
            w_we         = 1'b1;
            w_waddr      = r_hold_rd;
            w_wdata      = r_hold_data;
            w_state_next = S_IDLE;
            if (w_lu_req) begin
               w_wait_cnt_next = w_wait_inc;
            end else if (!i_lu_valid) begin
               w_wait_cnt_next = '0;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_wait_cnt   <= '0;
         r_hold_valid <= 1'b0;
         r_hold_rd    <= 5'd0;
         r_hold_data  <= 32'd0;
         r_proto_err  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_wait_cnt <= w_wait_cnt_next;
         if (w_capture) begin
            r_hold_valid <= 1'b1;
            r_hold_rd    <= i_pipe_rd;
            r_hold_data  <= w_pipe_data;
         end else if (r_state == S_HOLD) begin
            r_hold_valid <= 1'b0;
         end
         // Upstream ignored the stall: the pipe write is lost, flag it.
         if ((r_state == S_HOLD) && w_pipe_req) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   // Combinational outputs are held quiet while reset is asserted.
   assign o_rf_we      = rst_n && w_we;
   assign o_rf_waddr   = rst_n ? w_waddr : 5'd0;
   assign o_rf_wdata   = rst_n ? w_wdata : 32'd0;
   assign o_lu_ready   = rst_n && w_lu_ready;
   assign o_stall_req  = rst_n && w_stall;
   assign o_hold_valid = r_hold_valid;
   assign o_hold_rd    = r_hold_rd;
   assign o_hold_data  = r_hold_data;
   assign o_proto_err  = r_proto_err;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_port_arbiter
//
// Two arbiters side by side: index 0 with STARVE_LIMIT=4, index 1 with
// STARVE_LIMIT=0. Directed steps from the test plan are followed by random
// traffic. Each cycle both instances are compared against a behavioural model
// that tracks a lost-cycle count and a deferred pipe write.
// ---------------------------------------------------------------------------
module tb_wb_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        pipe_we   [2];
   logic [4:0]  pipe_rd   [2];
   logic [31:0] pipe_alu  [2];
   logic [31:0] pipe_mem  [2];
   logic        pipe_m2r  [2];
   logic        lu_valid  [2];
   logic [4:0]  lu_rd     [2];
   logic [31:0] lu_data   [2];
   logic        lu_ready  [2];
   logic        rf_we     [2];
   logic [4:0]  rf_waddr  [2];
   logic [31:0] rf_wdata  [2];
   logic        stall     [2];
   logic        hold_valid[2];
   logic [4:0]  hold_rd   [2];
   logic [31:0] hold_data [2];
   logic        proto_err [2];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         wb_port_arbiter #(.STARVE_LIMIT(gi == 0 ? 4 : 0)) u_dut (
            .clk               (clk),
            .rst_n             (rst_n),
            .i_pipe_reg_write  (pipe_we[gi]),
            .i_pipe_rd         (pipe_rd[gi]),
            .i_pipe_alu_result (pipe_alu[gi]),
            .i_pipe_mem_data   (pipe_mem[gi]),
            .i_pipe_mem_to_reg (pipe_m2r[gi]),
            .i_lu_valid        (lu_valid[gi]),
            .i_lu_rd           (lu_rd[gi]),
            .i_lu_data         (lu_data[gi]),
            .o_lu_ready        (lu_ready[gi]),
            .o_rf_we           (rf_we[gi]),
            .o_rf_waddr        (rf_waddr[gi]),
            .o_rf_wdata        (rf_wdata[gi]),
            .o_stall_req       (stall[gi]),
            .o_hold_valid      (hold_valid[gi]),
            .o_hold_rd         (hold_rd[gi]),
            .o_hold_data       (hold_data[gi]),
            .o_proto_err       (proto_err[gi])
         );
      end
   endgenerate

   int checks = 0;
   int errors = 0;

   // Reference model state
   int          m_lim [2] = '{4, 0};
   int          m_lost[2];            // cycles the pending LU has lost
   bit          m_dv  [2];            // displaced pipe write awaiting commit
   logic [4:0]  m_drd [2];
   logic [31:0] m_dd  [2];
   bit          m_perr[2];
   bit          lu_acc[2];
   bit          e_we[2], e_ready[2], e_stall[2];
   logic [4:0]  e_addr[2];
   logic [31:0] e_data[2];

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[%0d]: observed %h expected %h", tag, k, obs, exp);
      end
   endtask

   function automatic bit p_req(int k);
      return pipe_we[k] && (pipe_rd[k] != 5'd0);
   endfunction
   function automatic bit l_req(int k);
      return lu_valid[k] && (lu_rd[k] != 5'd0);
   endfunction
   function automatic logic [31:0] p_data(int k);
      return pipe_m2r[k] ? pipe_mem[k] : pipe_alu[k];
   endfunction

   task automatic model_eval(input int k);
      e_we[k] = 0; e_ready[k] = 0; e_stall[k] = 0; e_addr[k] = 0; e_data[k] = 0;
      if (rst_n) begin
         e_ready[k] = lu_valid[k] && (lu_rd[k] == 5'd0);
         if (m_dv[k]) begin
            e_we[k] = 1; e_addr[k] = m_drd[k]; e_data[k] = m_dd[k];
         end else if (p_req(k) && l_req(k) && m_lost[k] >= m_lim[k]) begin
            e_we[k] = 1; e_addr[k] = lu_rd[k]; e_data[k] = lu_data[k];
            e_ready[k] = 1; e_stall[k] = 1;
         end else if (p_req(k)) begin
            e_we[k] = 1; e_addr[k] = pipe_rd[k]; e_data[k] = p_data(k);
         end else if (l_req(k)) begin
            e_we[k] = 1; e_addr[k] = lu_rd[k]; e_data[k] = lu_data[k]; e_ready[k] = 1;
         end
      end
   endtask

   task automatic model_commit(input int k);
      if (!rst_n) begin
         m_lost[k] = 0; m_dv[k] = 0; m_drd[k] = 0; m_dd[k] = 0; m_perr[k] = 0;
      end else if (m_dv[k]) begin
         if (p_req(k)) m_perr[k] = 1;
         m_dv[k] = 0;
         if (l_req(k)) m_lost[k] = (m_lost[k] + 1 > m_lim[k]) ? m_lim[k] : m_lost[k] + 1;
         else if (!lu_valid[k]) m_lost[k] = 0;
      end else if (p_req(k) && l_req(k) && m_lost[k] >= m_lim[k]) begin
         m_dv[k] = 1; m_drd[k] = pipe_rd[k]; m_dd[k] = p_data(k); m_lost[k] = 0;
      end else if (p_req(k) && l_req(k)) begin
         m_lost[k] = (m_lost[k] + 1 > m_lim[k]) ? m_lim[k] : m_lost[k] + 1;
      end else if (l_req(k) || !lu_valid[k]) begin
         m_lost[k] = 0;
      end
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic tick();
      #1;
      for (int k = 0; k < 2; k++) begin
         model_eval(k);
         chk("rf_we", k, rf_we[k], e_we[k]);
         chk("lu_ready", k, lu_ready[k], e_ready[k]);
         chk("stall_req", k, stall[k], e_stall[k]);
         chk("hold_valid", k, hold_valid[k], rst_n ? m_dv[k] : 1'b0);
         chk("proto_err", k, proto_err[k], rst_n ? m_perr[k] : 1'b0);
         if (e_we[k] || !rst_n) begin
            chk("rf_waddr", k, rf_waddr[k], e_addr[k]);
            chk("rf_wdata", k, rf_wdata[k], e_data[k]);
         end
         if (m_dv[k] && rst_n) begin
            chk("hold_rd", k, hold_rd[k], m_drd[k]);
            chk("hold_data", k, hold_data[k], m_dd[k]);
         end
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         lu_acc[k] = e_ready[k];
         model_commit(k);
      end
      @(negedge clk);
   endtask

   task automatic set_pipe(input int k, input bit we, input logic [4:0] rd,
                           input logic [31:0] alu, input logic [31:0] mem, input bit m2r);
      pipe_we[k] = we; pipe_rd[k] = rd; pipe_alu[k] = alu; pipe_mem[k] = mem; pipe_m2r[k] = m2r;
   endtask
   task automatic set_lu(input int k, input bit v, input logic [4:0] rd, input logic [31:0] d);
      lu_valid[k] = v; lu_rd[k] = rd; lu_data[k] = d;
   endtask
   task automatic idle(input int k);
      set_pipe(k, 0, 0, 0, 0, 0);
      set_lu(k, 0, 0, 0);
   endtask

   task automatic drive_random(input int k);
      // Respect the bubble after a stall, except for an occasional violation.
      if (m_dv[k] && $urandom_range(0, 19) != 0) pipe_we[k] = 0;
      else pipe_we[k] = ($urandom_range(0, 9) < 7);
      pipe_rd[k]  = 5'($urandom_range(0, 31));
      pipe_alu[k] = $urandom;
      pipe_mem[k] = $urandom;
      pipe_m2r[k] = 1'($urandom_range(0, 1));
      if (!(lu_valid[k] && !lu_acc[k])) begin
         lu_valid[k] = 1'($urandom_range(0, 1));
         lu_rd[k]    = 5'($urandom_range(0, 31));
         lu_data[k]  = $urandom;
      end
   endtask

   initial begin
      rst_n = 0;
      idle(0); idle(1);
      for (int k = 0; k < 2; k++) begin
         m_lost[k] = 0; m_dv[k] = 0; m_drd[k] = 0; m_dd[k] = 0; m_perr[k] = 0; lu_acc[k] = 1;
      end
      @(negedge clk);
      tick(); tick();
      rst_n = 1;
      tick();

      // Pipe only
      set_pipe(0, 1, 5, 32'h1234, 32'h0, 0); #1;
      chk("pipe_we", 0, rf_we[0], 1); chk("pipe_addr", 0, rf_waddr[0], 5);
      chk("pipe_alu", 0, rf_wdata[0], 32'h1234);
      tick();
      set_pipe(0, 1, 5, 32'h1234, 32'hBEEF, 1); #1;
      chk("pipe_mem", 0, rf_wdata[0], 32'hBEEF);
      tick();
      set_pipe(0, 1, 0, 32'h1234, 32'h0, 0); #1;
      chk("pipe_x0", 0, rf_we[0], 0);
      tick();
      idle(0);

      // LU only
      set_lu(0, 1, 7, 32'hA5A5A5A5); #1;
      chk("lu_ready", 0, lu_ready[0], 1); chk("lu_addr", 0, rf_waddr[0], 7);
      chk("lu_data", 0, rf_wdata[0], 32'hA5A5A5A5);
      tick();
      set_lu(0, 1, 0, 32'h77); #1;
      chk("lu_x0_ready", 0, lu_ready[0], 1); chk("lu_x0_we", 0, rf_we[0], 0);
      tick();
      idle(0); tick();

      // Starvation with limit 4
      set_lu(0, 1, 9, 32'h900D);
      for (int i = 1; i <= 4; i++) begin
         set_pipe(0, 1, 5'(i), i * 32'h11, 32'h0, 0); #1;
         chk("starve_win_addr", 0, rf_waddr[0], i);
         chk("starve_win_stall", 0, stall[0], 0);
         chk("starve_win_ready", 0, lu_ready[0], 0);
         tick();
      end
      set_pipe(0, 1, 5, 32'h55, 32'h0, 0); #1;
      chk("forced_addr", 0, rf_waddr[0], 9); chk("forced_data", 0, rf_wdata[0], 32'h900D);
      chk("forced_stall", 0, stall[0], 1); chk("forced_ready", 0, lu_ready[0], 1);
      tick();
      idle(0); #1;
      chk("held_addr", 0, rf_waddr[0], 5); chk("held_data", 0, rf_wdata[0], 32'h55);
      chk("held_stall", 0, stall[0], 0); chk("held_hv", 0, hold_valid[0], 1);
      tick();
      set_pipe(0, 1, 6, 32'h66, 32'h0, 0); #1;
      chk("after_addr", 0, rf_waddr[0], 6); chk("after_hv", 0, hold_valid[0], 0);
      tick();
      // Counter restarted: the next conflict goes to the pipe
      set_pipe(0, 1, 1, 32'h101, 32'h0, 0); set_lu(0, 1, 10, 32'hA0); #1;
      chk("restart_addr", 0, rf_waddr[0], 1); chk("restart_ready", 0, lu_ready[0], 0);
      tick();
      set_pipe(0, 0, 0, 0, 0, 0); #1;
      chk("restart_lu", 0, rf_waddr[0], 10);
      tick();
      idle(0); tick();

      // Limit 0: LU wins the first conflict
      set_pipe(1, 1, 3, 32'h33, 32'h0, 0); set_lu(1, 1, 4, 32'h44); #1;
      chk("lim0_addr", 1, rf_waddr[1], 4); chk("lim0_stall", 1, stall[1], 1);
      chk("lim0_ready", 1, lu_ready[1], 1);
      tick();
      idle(1); #1;
      chk("lim0_held_addr", 1, rf_waddr[1], 3); chk("lim0_held_data", 1, rf_wdata[1], 32'h33);
      tick();

      // Protocol error: pipe write during HOLD
      set_pipe(1, 1, 8, 32'h88, 32'h0, 0); set_lu(1, 1, 12, 32'hCC);
      tick();
      set_lu(1, 0, 0, 0); set_pipe(1, 1, 9, 32'h99, 32'h0, 0); #1;
      chk("perr_held_addr", 1, rf_waddr[1], 8); chk("perr_held_data", 1, rf_wdata[1], 32'h88);
      tick();
      idle(1); #1;
      chk("perr_set", 1, proto_err[1], 1);
      tick(); tick(); #1;
      chk("perr_sticky", 1, proto_err[1], 1);
      tick();

      // Reset asserted mid-HOLD
      set_pipe(1, 1, 13, 32'hDD, 32'h0, 0); set_lu(1, 1, 14, 32'hEE);
      tick();
      idle(1); #1;
      chk("rst_pre_hv", 1, hold_valid[1], 1);
      rst_n = 0; #1;
      chk("rst_we", 1, rf_we[1], 0); chk("rst_hv", 1, hold_valid[1], 0);
      chk("rst_perr", 1, proto_err[1], 0); chk("rst_waddr", 1, rf_waddr[1], 0);
      tick();
      rst_n = 1; #1;
      chk("rst_drop_we", 1, rf_we[1], 0);
      tick();

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         drive_random(0);
         drive_random(1);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
